// File: rtl/rx_byte_assembler_if.sv
// rx_byte_assembler_if: bit-level frame events in, byte-level frame events out
interface rx_byte_assembler_if;
    logic       in_soc;
    logic       in_eoc;
    logic       in_error;
    logic       in_data_valid;
    logic       in_data;
    logic       out_soc;
    logic       out_eoc;
    logic       out_error;
    logic       out_data_valid;
    logic [7:0] out_data;
    logic [2:0] out_data_bits;
    modport master (
        output in_soc, in_eoc, in_error, in_data_valid, in_data,
        input  out_soc, out_eoc, out_error, out_data_valid, out_data, out_data_bits
    );
    modport slave (
        input  in_soc, in_eoc, in_error, in_data_valid, in_data,
        output out_soc, out_eoc, out_error, out_data_valid, out_data, out_data_bits
    );
endinterface

// File: rtl/rx_byte_assembler.sv
// rx_byte_assembler: packs LSB-first rx bits into bytes; RX_BYTE_PARITY_EN adds odd-parity check per byte
module rx_byte_assembler #(
    parameter int MAX_BYTES = 0
) (
    input  logic              clk,
    input  logic              rst,
    rx_byte_assembler_if.slave rx
);
    localparam int BCW = MAX_BYTES > 0 ? $clog2(MAX_BYTES + 2) : 1;
    localparam logic [BCW-1:0] BC_SAT = BCW'(MAX_BYTES + 1);
`ifdef RX_BYTE_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, ERROR} state_t;
`endif
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d, byte_inc;
    logic [7:0]     shreg_q, shreg_d;
    logic           soc_q, soc_d, eoc_q, eoc_d, err_q, err_d, dv_q, dv_d;
    logic [7:0]     data_q, data_d;
    logic [2:0]     bits_q, bits_d;
    logic           limit_hit;

    assign limit_hit = (MAX_BYTES != 0) && (byte_cnt_q == BCW'(MAX_BYTES));
    assign byte_inc  = byte_cnt_q == BC_SAT ? byte_cnt_q : byte_cnt_q + 1'b1;

    // frame FSM: SOC restarts from any state; errors and EOC outrank data bits
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        soc_d      = 1'b0;
        eoc_d      = 1'b0;
        err_d      = 1'b0;
        dv_d       = 1'b0;
        data_d     = 8'd0;
        bits_d     = 3'd0;
        if (rx.in_soc) begin
            soc_d      = 1'b1;
            state_d    = DATA;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            shreg_d    = 8'd0;
        end else if (state_q == IDLE) begin
            state_d = IDLE;
        end else if (state_q == ERROR) begin
            if (rx.in_eoc) begin
                eoc_d   = 1'b1;
                state_d = IDLE;
            end
        end else if (rx.in_error) begin
            err_d   = 1'b1;
            eoc_d   = rx.in_eoc;
            state_d = rx.in_eoc ? IDLE : ERROR;
        end else if (rx.in_eoc) begin
            eoc_d   = 1'b1;
            state_d = IDLE;
            dv_d    = bit_cnt_q != 3'd0;
            bits_d  = bit_cnt_q;
            data_d  = dv_d ? shreg_q : 8'd0;
`ifdef RX_BYTE_PARITY_EN
            err_d   = state_q == PARITY;
`endif
        end else if (rx.in_data_valid) begin
`ifdef RX_BYTE_PARITY_EN
            if (state_q == PARITY) begin
                shreg_d = 8'd0;
                if (^{shreg_q, rx.in_data} && !limit_hit) begin
                    dv_d       = 1'b1;
                    data_d     = shreg_q;
                    byte_cnt_d = byte_inc;
                    state_d    = DATA;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end
            end else begin
                shreg_d[bit_cnt_q] = rx.in_data;
                bit_cnt_d          = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
`else
            shreg_d[bit_cnt_q] = rx.in_data;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                shreg_d = 8'd0;
                if (limit_hit) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    dv_d       = 1'b1;
                    data_d     = {rx.in_data, shreg_q[6:0]};
                    byte_cnt_d = byte_inc;
                end
            end
`endif
        end
    end

    // state, counters and registered single-cycle output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            shreg_q    <= 8'd0;
            soc_q      <= 1'b0;
            eoc_q      <= 1'b0;
            err_q      <= 1'b0;
            dv_q       <= 1'b0;
            data_q     <= 8'd0;
            bits_q     <= 3'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            soc_q      <= soc_d;
            eoc_q      <= eoc_d;
            err_q      <= err_d;
            dv_q       <= dv_d;
            data_q     <= data_d;
            bits_q     <= bits_d;
        end
    end

    assign rx.out_soc        = soc_q;
    assign rx.out_eoc        = eoc_q;
    assign rx.out_error      = err_q;
    assign rx.out_data_valid = dv_q;
    assign rx.out_data       = data_q;
    assign rx.out_data_bits  = bits_q;
endmodule
